// File: rtl/arith_share_arbiter_if.sv
// Requester, response and shared-datapath signals for arith_share_arbiter.
// slave = arbiter side, master = client/datapath side.
interface arith_share_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic       req0_op;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic       req1_valid;
  logic       req1_ready;
  logic       req1_op;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic       rsp0_valid;
  logic       rsp0_ready;
  logic [7:0] rsp0_data;
  logic       rsp1_valid;
  logic       rsp1_ready;
  logic [7:0] rsp1_data;
  logic [3:0] dp_a;
  logic [3:0] dp_b;
  logic [3:0] dp_sum;
  logic       dp_carry;
  logic [7:0] dp_product;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    input  dp_sum, dp_carry, dp_product,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output dp_a, dp_b
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    output dp_sum, dp_carry, dp_product,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  dp_a, dp_b
  );
endinterface

// File: rtl/arith_share_arbiter.sv
// Two-requester sequencer for a shared external 4-bit add / 4x4 multiply datapath.
// Optional ARB_GRANT_CNT_EN adds per-requester 8-bit wrapping grant counters.
module arith_share_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter bit INIT_PRI    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  arith_share_arbiter_if.slave  bus,
  output logic                  busy
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [7:0]            grant_cnt0,
  output logic [7:0]            grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q;
  logic       pri_q;
  logic       op_q;
  logic       gnt_q;
  logic       busy_q;
  logic [3:0] dp_a_q;
  logic [3:0] dp_b_q;
  logic       rsp0_valid_q;
  logic       rsp1_valid_q;
  logic [7:0] rsp0_data_q;
  logic [7:0] rsp1_data_q;

  logic       win1_d;
  logic       accept_d;
  logic       op_d;
  logic [3:0] a_d;
  logic [3:0] b_d;
  logic [7:0] result_d;
  logic       rsp_take_d;

  // Requester 1 wins when alone, or on a tie when it holds the round-robin pointer.
  assign win1_d     = bus.req1_valid & (~bus.req0_valid | (ROUND_ROBIN & pri_q));
  assign bus.req0_ready = (state_q == IDLE) & bus.req0_valid & ~win1_d;
  assign bus.req1_ready = (state_q == IDLE) & win1_d;
  assign accept_d   = bus.req0_ready | bus.req1_ready;
  assign op_d       = win1_d ? bus.req1_op : bus.req0_op;
  assign a_d        = win1_d ? bus.req1_a  : bus.req0_a;
  assign b_d        = win1_d ? bus.req1_b  : bus.req0_b;
  assign result_d   = op_q ? bus.dp_product : {3'b000, bus.dp_carry, bus.dp_sum};
  assign rsp_take_d = gnt_q ? (bus.rsp1_ready & rsp1_valid_q)
                            : (bus.rsp0_ready & rsp0_valid_q);

  assign bus.dp_a       = dp_a_q;
  assign bus.dp_b       = dp_b_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp1_data  = rsp1_data_q;
  assign busy           = busy_q;

  // Sequencer FSM with registered datapath-operand and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pri_q        <= INIT_PRI;
      op_q         <= 1'b0;
      gnt_q        <= 1'b0;
      busy_q       <= 1'b0;
      dp_a_q       <= 4'h0;
      dp_b_q       <= 4'h0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= 8'h00;
      rsp1_data_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            op_q    <= op_d;
            gnt_q   <= win1_d;
            dp_a_q  <= a_d;
            dp_b_q  <= b_d;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // Operands are only presented during this single cycle.
          dp_a_q  <= 4'h0;
          dp_b_q  <= 4'h0;
          state_q <= RESP;
          if (gnt_q) begin
            rsp1_valid_q <= 1'b1;
            rsp1_data_q  <= result_d;
          end else begin
            rsp0_valid_q <= 1'b1;
            rsp0_data_q  <= result_d;
          end
        end
        RESP: begin
          if (rsp_take_d) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= 8'h00;
            rsp1_data_q  <= 8'h00;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
            if (ROUND_ROBIN) begin
              pri_q <= ~pri_q;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          dp_a_q       <= 4'h0;
          dp_b_q       <= 4'h0;
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          rsp0_data_q  <= 8'h00;
          rsp1_data_q  <= 8'h00;
        end
      endcase
    end
  end

`ifdef ARB_GRANT_CNT_EN
  logic [7:0] grant_cnt0_q;
  logic [7:0] grant_cnt1_q;

  // Per-requester accept counters, wrapping naturally at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0_q <= 8'h00;
      grant_cnt1_q <= 8'h00;
    end else begin
      if (bus.req0_ready) begin
        grant_cnt0_q <= grant_cnt0_q + 8'h01;
      end
      if (bus.req1_ready) begin
        grant_cnt1_q <= grant_cnt1_q + 8'h01;
      end
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule
